// File: rtl/imem_loader_if.sv
// Byte-stream, memory-write and control/status signals between the loader and its host.
// The loader takes the slave view; the host (programmer + instruction memory) takes the master view.
interface imem_loader_if #(
  parameter int n      = 32,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [6:0]        word_count;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [n-1:0]      wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [n-1:0]      checksum;

  modport master (
    output start, word_count, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, checksum
  );

  modport slave (
    input  start, word_count, abort, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: packs little-endian bytes into 32-bit words, writes them
// from address 0 upward, holds the core while loading and reports an XOR checksum at the end.
//
// state    | meaning
// ST_IDLE  | waiting for start; core released
// ST_RECV  | accepting bytes of the current word
// ST_WRITE | one-cycle write strobe of the assembled word
// ST_DONE  | one-cycle done pulse; checksum valid
module imem_loader #(
  parameter int n      = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_idx;
  logic [23:0]       byte_buf;
  logic [6:0]        word_cnt;
  logic [6:0]        cnt_clamp;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [n-1:0]      wr_data_q;
  logic [n-1:0]      checksum_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic              cpu_hold_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;

  assign cnt_clamp = (bus.word_count > 7'(DEPTH)) ? 7'(DEPTH) : bus.word_count;
  assign accept    = bus.in_valid && in_ready_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = (cnt_clamp == 7'd0) ? ST_DONE : ST_RECV;
      end
      ST_RECV: begin
        if (bus.abort) state_nxt = ST_IDLE;
        else if (accept && byte_idx == 2'd3) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        // the write of this cycle completes regardless of abort
        if (bus.abort) state_nxt = ST_IDLE;
        else if (word_cnt == 7'd1) state_nxt = ST_DONE;
        else state_nxt = ST_RECV;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      byte_idx   <= 2'd0;
      byte_buf   <= 24'd0;
      word_cnt   <= 7'd0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      checksum_q <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      // outputs are decoded from the next state so they line up with the state register
      in_ready_q <= (state_nxt == ST_RECV);
      wr_en_q    <= (state_nxt == ST_WRITE);
      cpu_hold_q <= (state_nxt == ST_RECV) || (state_nxt == ST_WRITE);
      busy_q     <= (state_nxt == ST_RECV) || (state_nxt == ST_WRITE);
      done_q     <= (state_nxt == ST_DONE);

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            word_cnt   <= cnt_clamp;
            wr_addr_q  <= '0;
            byte_idx   <= 2'd0;
            checksum_q <= '0;
          end
        end
        ST_RECV: begin
          if (bus.abort) begin
            byte_idx <= 2'd0;
          end else if (accept) begin
            if (byte_idx == 2'd3) begin
              wr_data_q <= {bus.in_data, byte_buf};
              byte_idx  <= 2'd0;
            end else begin
              byte_buf[{byte_idx, 3'b000} +: 8] <= bus.in_data;
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          checksum_q <= checksum_q ^ wr_data_q;
          word_cnt   <= word_cnt - 7'd1;
          wr_addr_q  <= wr_addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.checksum = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and
// popped when the loader raises wr_en.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.n(32), .ADDR_W(6)) bus ();

  imem_loader #(.n(32), .ADDR_W(6), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc_cnt = 0;
  int          wr_cnt  = 0;
  int          done_cnt = 0;
  logic [37:0] sb_q[$];
  logic [31:0] words[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic mon();
    logic [37:0] e;
    if (rst) begin
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (bus.wr_en) begin
        wr_cnt++;
        chk("rdy_in_wr", 32'(bus.in_ready), 32'd0);
        if (sb_q.size() == 0) begin
          chk("wr_unexp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e[37:32]));
          chk("wr_data", bus.wr_data, e[31:0]);
        end
      end
      if (bus.done) done_cnt++;
    end
  endtask

  // inputs change 1 ns after the rising edge, outputs are observed on the falling edge
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (!ok) chk("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic fill_words(input int cnt);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back($urandom() | 32'h1);
  endtask

  task automatic run_load(input int wc, input int gap, input int poke);
    int          eff;
    logic [31:0] cs;
    logic [31:0] w;
    int          acc0, wr0, d0;
    eff  = (wc > 64) ? 64 : wc;
    cs   = 32'd0;
    acc0 = acc_cnt;
    wr0  = wr_cnt;
    d0   = done_cnt;
    for (int i = 0; i < eff; i++) begin
      cs ^= words[i];
      sb_q.push_back({6'(i), words[i]});
    end
    bus.word_count = 7'(wc);
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    if (eff == 0) begin
      chk("zero_done", 32'(bus.done), 32'd1);
      chk("zero_cs", bus.checksum, 32'd0);
    end else begin
      chk("hold_on", 32'(bus.cpu_hold), 32'd1);
      for (int b = 0; b < eff * 4; b++) begin
        w = words[b / 4];
        if (b == poke) begin
          bus.start      = 1'b1;
          bus.word_count = 7'd1;
        end
        send_byte(w[8 * (b % 4) +: 8], gap);
        bus.start = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("wr_en_last", 32'(bus.wr_en), 32'd1);
      tick();
      chk("done", 32'(bus.done), 32'd1);
      chk("checksum", bus.checksum, cs);
      chk("hold_off", 32'(bus.cpu_hold), 32'd0);
    end
    tick();
    chk("done_1cyc", 32'(bus.done), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("acc_cnt", 32'(acc_cnt - acc0), 32'(eff * 4));
    chk("wr_cnt", 32'(wr_cnt - wr0), 32'(eff));
    chk("done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, wr0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.word_count = 7'd0;
    bus.abort      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'd0;
    tick();
    tick();
    chk("rst_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_data", bus.wr_data, 32'd0);
    chk("rst_cs", bus.checksum, 32'd0);
    chk("rst_outs", {27'd0, bus.in_ready, bus.wr_en, bus.cpu_hold, bus.busy, bus.done}, 32'd0);
    rst = 1'b1;
    tick();

    // basic two-word load, back-to-back bytes
    words.delete();
    words.push_back(32'h0000_0033);
    words.push_back(32'h0000_2083);
    run_load(2, 0, -1);
    chk("basic_cs", bus.checksum, 32'h0000_20B0);

    // same stream with in_valid toggling
    run_load(2, 1, -1);

    // zero count
    run_load(0, 0, -1);

    // clamp to 64 words, address wraps afterwards
    fill_words(64);
    run_load(100, 0, -1);
    chk("wrap_addr", 32'(bus.wr_addr), 32'd0);

    // abort mid-word on the second word
    fill_words(3);
    sb_q.push_back({6'd0, words[0]});
    d0  = done_cnt;
    wr0 = wr_cnt;
    bus.word_count = 7'd3;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 6; b++) begin
      logic [31:0] w;
      w = words[b / 4];
      send_byte(w[8 * (b % 4) +: 8], 0);
    end
    bus.in_valid = 1'b0;
    bus.abort    = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hold", 32'(bus.cpu_hold), 32'd0);
    chk("abort_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
    chk("abort_wr", 32'(wr_cnt - wr0), 32'd1);
    chk("abort_sb", 32'(sb_q.size()), 32'd0);
    fill_words(2);
    run_load(2, 0, -1);

    // async reset between edges during the second word
    fill_words(2);
    sb_q.push_back({6'd0, words[0]});
    bus.word_count = 7'd2;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 6; b++) begin
      logic [31:0] w;
      w = words[b / 4];
      send_byte(w[8 * (b % 4) +: 8], 0);
    end
    chk("pre_rst_addr", 32'(bus.wr_addr), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_hold", 32'(bus.cpu_hold), 32'd0);
    chk("arst_rdy", 32'(bus.in_ready), 32'd0);
    chk("arst_addr", 32'(bus.wr_addr), 32'd0);
    chk("arst_data", bus.wr_data, 32'd0);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst_sb", 32'(sb_q.size()), 32'd0);
    fill_words(3);
    run_load(3, 0, -1);

    // start pulsed mid-load with a different count is ignored
    fill_words(3);
    run_load(3, 1, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
